mem_arbiter: RTL

Two-port arbiter that shares the single-port `memory` block between the instruction-fetch requester (`i_*`) and the data requester (`d_*`). It sits between the core's fetch/load-store units and `memory`. It allows at most one transaction in flight, holds address, write data and mask stable for the memory's two-cycle write, and routes each `rvalid`/`rdata` back to the requester that issued the transaction.

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of the single-port memory: one transaction in flight,
// payload held through the write-commit cycle. Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin grant.
module mem_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic                    i_wen,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wmask,
  output logic                    i_rvalid,
  output logic [DATA_WIDTH-1:0]   i_rdata,

  input  logic                    d_valid,
  output logic                    d_ready,
  input  logic                    d_wen,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,

  input  logic                    mem_ready,
  output logic                    mem_valid,
  output logic                    mem_wen,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  logic                  busy;
  owner_e                owner;
  owner_e                grant;
  logic                  can_issue;
  logic                  issue;

  logic                  lat_wen;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [MASK_WIDTH-1:0] lat_wmask;

  logic                  req_wen;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [MASK_WIDTH-1:0] req_wmask;

  // A returning response frees the slot in the same cycle, so reads can run back-to-back.
  assign can_issue = mem_ready && (!busy || mem_rvalid);
  assign issue     = can_issue && (i_valid || d_valid);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  owner_e last;

  always_comb begin
    grant = OWN_I;
    if (i_valid && d_valid) grant = (last == OWN_I) ? OWN_D : OWN_I;
    else if (d_valid)       grant = OWN_D;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       last <= OWN_I;
    else if (issue) last <= grant;
  end
`else
  assign grant = d_valid ? OWN_D : OWN_I;
`endif

  assign i_ready   = can_issue && i_valid && (grant == OWN_I);
  assign d_ready   = can_issue && d_valid && (grant == OWN_D);
  assign mem_valid = issue;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    req_wen   = i_wen;
    req_addr  = i_addr;
    req_wdata = i_wdata;
    req_wmask = i_wmask;
    if (grant == OWN_D) begin
      req_wen   = d_wen;
      req_addr  = d_addr;
      req_wdata = d_wdata;
      req_wmask = d_wmask;
    end
  end

  // Outside the issue cycle the memory sees the latched payload, which is what it
  // commits during the second cycle of a write.
  always_comb begin
    mem_wen   = lat_wen;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    mem_wmask = lat_wmask;
    if (issue) begin
      mem_wen   = req_wen;
      mem_addr  = req_addr;
      mem_wdata = req_wdata;
      mem_wmask = req_wmask;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst) begin
      busy      <= 1'b0;
      owner     <= OWN_I;
      lat_wen   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wmask <= '0;
    end else if (issue) begin
      busy      <= 1'b1;
      owner     <= grant;
      lat_wen   <= req_wen;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_wmask <= req_wmask;
    end else if (mem_rvalid) begin
      busy      <= 1'b0;
    end
  end

  // Responses arriving while idle (including after a reset) are dropped.
  assign i_rvalid = mem_rvalid && busy && (owner == OWN_I);
  assign d_rvalid = mem_rvalid && busy && (owner == OWN_D);
  assign i_rdata  = (busy && owner == OWN_I) ? mem_rdata : '0;
  assign d_rdata  = (busy && owner == OWN_D) ? mem_rdata : '0;

endmodule
